// File: rtl/keypad_scanner_if.sv
// Keypad pin and decoded-key bundle between the scanner and the board/display side.
interface keypad_scanner_if;
   logic [3:0] cols;
   logic [3:0] rows;
   logic [3:0] key_n;
   logic       key_valid;
   logic       key_held;

   modport master (input cols, output rows, key_n, key_valid, key_held);
   modport slave  (output cols, input rows, key_n, key_valid, key_held);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad row scanner with press/release debounce; emits the key code active-low.
// state       | meaning
// SCAN        | rotate rows, sample cols on last dwell cycle
// DEB_PRESS   | row frozen, waiting for stable single-key pattern
// HELD        | key accepted, waiting for latched column to rise
// DEB_RELEASE | latched column high, waiting for stable release
module keypad_scanner #(
   parameter int SCAN_DIV        = 24000,
   parameter int DEBOUNCE_CYCLES = 480000
) (
   input logic             clk,
   input logic             reset,
   keypad_scanner_if.master bus
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DEB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_RELEASE} state_t;

   state_t           state;
   logic [3:0]       cs_meta;
   logic [3:0]       cs;
   logic [DIV_W-1:0] dwell;
   logic [DEB_W-1:0] deb;
   logic [1:0]       row_idx;
   logic [3:0]       rows_q;
   logic [3:0]       lat_pat;
   logic [3:0]       lat_code;
   logic [3:0]       key_n_q;
   logic             key_valid_q;
   logic             key_held_q;
   logic             one_low;
   logic [1:0]       col_idx;
   logic             released;

   function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] code;
      case ({r, c})
         4'h0:    code = 4'h1;
         4'h1:    code = 4'h2;
         4'h2:    code = 4'h3;
         4'h3:    code = 4'hA;
         4'h4:    code = 4'h4;
         4'h5:    code = 4'h5;
         4'h6:    code = 4'h6;
         4'h7:    code = 4'hB;
         4'h8:    code = 4'h7;
         4'h9:    code = 4'h8;
         4'hA:    code = 4'h9;
         4'hB:    code = 4'hC;
         4'hC:    code = 4'hE;
         4'hD:    code = 4'h0;
         4'hE:    code = 4'hF;
         default: code = 4'hD;
      endcase
      return code;
   endfunction

   always_comb begin
      one_low = 1'b1;
      col_idx = 2'd0;
      case (cs)
         4'b1110: col_idx = 2'd0;
         4'b1101: col_idx = 2'd1;
         4'b1011: col_idx = 2'd2;
         4'b0111: col_idx = 2'd3;
         default: one_low = 1'b0;
      endcase
   end

   // Only the latched column decides release; other columns are ignored once held.
   assign released = |(cs & ~lat_pat);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= SCAN;
         cs_meta     <= 4'hF;
         cs          <= 4'hF;
         dwell       <= '0;
         deb         <= '0;
         row_idx     <= 2'd0;
         rows_q      <= 4'b1110;
         lat_pat     <= 4'hF;
         lat_code    <= 4'h0;
         key_n_q     <= 4'hF;
         key_valid_q <= 1'b0;
         key_held_q  <= 1'b0;
      end else begin
         cs_meta     <= bus.cols;
         cs          <= cs_meta;
         key_valid_q <= 1'b0;
         case (state)
            SCAN: begin
               if (dwell == DIV_LAST) begin
                  dwell <= '0;
                  if (one_low) begin
                     lat_pat  <= cs;
                     lat_code <= key_code(row_idx, col_idx);
                     deb      <= '0;
                     state    <= DEB_PRESS;
                  end else begin
                     row_idx <= row_idx + 2'd1;
                     rows_q  <= {rows_q[2:0], rows_q[3]};
                  end
               end else begin
                  dwell <= dwell + 1'b1;
               end
            end
            DEB_PRESS: begin
               if (cs == lat_pat) begin
                  if (deb == DEB_LAST) begin
                     deb         <= '0;
                     key_n_q     <= ~lat_code;
                     key_valid_q <= 1'b1;
                     key_held_q  <= 1'b1;
                     state       <= HELD;
                  end else begin
                     deb <= deb + 1'b1;
                  end
               end else begin
                  dwell   <= '0;
                  row_idx <= row_idx + 2'd1;
                  rows_q  <= {rows_q[2:0], rows_q[3]};
                  state   <= SCAN;
               end
            end
            HELD: begin
               if (released) begin
                  deb   <= '0;
                  state <= DEB_RELEASE;
               end
            end
            DEB_RELEASE: begin
               if (released) begin
                  if (deb == DEB_LAST) begin
                     deb        <= '0;
                     dwell      <= '0;
                     key_held_q <= 1'b0;
                     row_idx    <= row_idx + 2'd1;
                     rows_q     <= {rows_q[2:0], rows_q[3]};
                     state      <= SCAN;
                  end else begin
                     deb <= deb + 1'b1;
                  end
               end else begin
                  deb   <= '0;
                  state <= HELD;
               end
            end
            default: state <= SCAN;
         endcase
      end
   end

   assign bus.rows      = rows_q;
   assign bus.key_n     = key_n_q;
   assign bus.key_valid = key_valid_q;
   assign bus.key_held  = key_held_q;

endmodule
